// File: rtl/vector_pkg.sv
// rtl/vector_pkg.sv - shared constants and types for the vector scheduler
package vector_pkg;

   localparam int MOD_W    = 2;
   localparam int SIZE_DEF = 3072;
   localparam int ID_MAX_W = 3;

   typedef logic [MOD_W-1:0] mod_t;

   // Widest id and default data width, so one entry type serves every legal NREQ.
   typedef struct packed {
      logic [ID_MAX_W-1:0] id;
      logic [SIZE_DEF-1:0] data;
   } rsp_entry_t;

   function automatic int id_width(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

endpackage

// File: rtl/vec_rsp_fifo.sv
// rtl/vec_rsp_fifo.sv - show-ahead synchronous FIFO with occupancy count
module vec_rsp_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_s_tdata,
   input  logic             i_s_tvalid,
   output logic [WIDTH-1:0] o_m_tdata,
   output logic             o_m_tvalid,
   input  logic             i_m_tready,
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_m_tvalid = (r_count != '0);
   assign o_m_tdata  = r_mem[r_rd_ptr];
   assign o_count    = r_count;
   assign w_pop      = o_m_tvalid & i_m_tready;
   // A pop frees the slot in the same cycle, so a full FIFO still accepts then.
   assign w_push     = i_s_tvalid & ((r_count != CNT_W'(DEPTH)) | w_pop);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_s_tdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/vector_sched.sv
// rtl/vector_sched.sv - round-robin scheduler sharing one vector unit among requesters
module vector_sched
   import vector_pkg::*;
#(
   parameter int SIZE       = SIZE_DEF,
   parameter int NREQ       = 4,
   parameter int VEC_LAT    = 1,
   parameter int FIFO_DEPTH = 4,
   localparam int ID_W      = id_width(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*SIZE-1:0] req_a,
   input  logic [NREQ*SIZE-1:0] req_b,
   input  logic [NREQ*2-1:0]    req_mod,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [SIZE-1:0]      rsp_data,
   output logic [SIZE-1:0]      vec_A,
   output logic [SIZE-1:0]      vec_B,
   output logic [1:0]           vec_mod,
   input  logic [SIZE-1:0]      vec_out,
   output logic                 busy
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

   if (FIFO_DEPTH < VEC_LAT + 1) begin : g_bad_depth
      $error("vector_sched: FIFO_DEPTH must be >= VEC_LAT+1");
   end
   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("vector_sched: NREQ must be in 2..8");
   end
   if (SIZE > SIZE_DEF) begin : g_bad_size
      $error("vector_sched: SIZE exceeds response entry width");
   end

   logic [SIZE-1:0] w_a_arr   [NREQ];
   logic [SIZE-1:0] w_b_arr   [NREQ];
   mod_t            w_mod_arr [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign w_a_arr[g]   = req_a[g*SIZE +: SIZE];
      assign w_b_arr[g]   = req_b[g*SIZE +: SIZE];
      assign w_mod_arr[g] = req_mod[g*2 +: 2];
   end

   logic [ID_W-1:0]  r_ptr;
   logic [SIZE-1:0]  r_vec_a;
   logic [SIZE-1:0]  r_vec_b;
   mod_t             r_vec_mod;
   logic [VEC_LAT:0] r_tag_v;
   logic [ID_W-1:0]  r_tag_id [VEC_LAT+1];
   logic [CNT_W-1:0] r_inflight;

   logic [CNT_W-1:0] w_fifo_count;
   logic [CNT_W:0]   w_used;
   logic             w_can_issue;
   logic             w_found;
   logic [ID_W-1:0]  w_grant;
   logic [ID_W-1:0]  w_idx;
   logic             w_accept;
   logic             w_push;
   logic             w_head_valid;
   rsp_entry_t       w_push_entry;
   rsp_entry_t       w_head;
   logic             w_unused;

   // Credit counts both in-flight tags and held entries, so every capture has a free slot.
   assign w_used      = {1'b0, r_inflight} + {1'b0, w_fifo_count};
   assign w_can_issue = !rst && (w_used < DEPTH_L);

   always_comb begin
      w_found = 1'b0;
      w_grant = '0;
      w_idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_idx = ID_W'((int'(r_ptr) + k) % NREQ);
         if (!w_found && req_valid[w_idx]) begin
            w_found = 1'b1;
            w_grant = w_idx;
         end
      end
   end

   assign w_accept  = w_found & w_can_issue;
   assign req_ready = w_accept ? (NREQ'(1) << w_grant) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr     <= ID_W'(NREQ - 1);
         r_vec_a   <= '0;
         r_vec_b   <= '0;
         r_vec_mod <= '0;
      end else if (w_accept) begin
         r_ptr     <= w_grant;
         r_vec_a   <= w_a_arr[w_grant];
         r_vec_b   <= w_b_arr[w_grant];
         r_vec_mod <= w_mod_arr[w_grant];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tag_v <= '0;
         for (int s = 0; s <= VEC_LAT; s++) begin
            r_tag_id[s] <= '0;
         end
      end else begin
         r_tag_v[0]  <= w_accept;
         r_tag_id[0] <= w_grant;
         for (int s = 1; s <= VEC_LAT; s++) begin
            r_tag_v[s]  <= r_tag_v[s-1];
            r_tag_id[s] <= r_tag_id[s-1];
         end
      end
   end

   assign w_push = r_tag_v[VEC_LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflight <= '0;
      end else begin
         case ({w_accept, w_push})
            2'b10:   r_inflight <= r_inflight + CNT_W'(1);
            2'b01:   r_inflight <= r_inflight - CNT_W'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   assign w_push_entry.id   = ID_MAX_W'(r_tag_id[VEC_LAT]);
   assign w_push_entry.data = SIZE_DEF'(vec_out);

   vec_rsp_fifo #(
      .WIDTH ($bits(rsp_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_rsp_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_s_tdata  (w_push_entry),
      .i_s_tvalid (w_push),
      .o_m_tdata  (w_head),
      .o_m_tvalid (w_head_valid),
      .i_m_tready (rsp_ready),
      .o_count    (w_fifo_count)
   );

   assign w_unused  = ^w_head.id;
   assign rsp_valid = !rst && w_head_valid;
   assign rsp_id    = rsp_valid ? w_head.id[ID_W-1:0] : '0;
   assign rsp_data  = rsp_valid ? w_head.data[SIZE-1:0] : '0;
   assign vec_A     = rst ? '0 : r_vec_a;
   assign vec_B     = rst ? '0 : r_vec_b;
   assign vec_mod   = rst ? '0 : r_vec_mod;
   assign busy      = !rst && (w_used != '0);

endmodule
